cci_mpf_prim_fifo2_rr_arb: RTL and testbench

- Shares one 2-entry, fully pipelined output buffer among N_REQ requesters.
- Each requester enqueues into a private 2-entry input buffer.
- A round-robin arbiter moves at most one entry per cycle from the input buffers into the output buffer.
- Used wherever several MPF request streams merge onto one channel without combinational paths from the consumer's deq_en to the producers' notFull.

---
 rtl/cci_mpf_prim_fifo2_rr_arb.sv | 166 ++++++++++++++++
 tb/tb_cci_mpf_prim_fifo2_rr_arb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_prim_fifo2_rr_arb.sv
// cci_mpf_prim_fifo2_rr_arb
// N_REQ private 2-entry input buffers merged by a round-robin arbiter into one
// shared 2-entry output buffer. Every output comes straight from a register, so
// the consumer's deq_en never reaches a producer's notFull combinationally.
module cci_mpf_prim_fifo2_rr_arb #(
  parameter int N_DATA_BITS = 32,
  parameter int N_REQ = 4,
  localparam int N_REQ_IDX_BITS = $clog2(N_REQ)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_REQ-1:0][N_DATA_BITS-1:0]    enq_data,
  input  logic [N_REQ-1:0]                     enq_en,
  output logic [N_REQ-1:0]                     notFull,
  output logic [N_DATA_BITS-1:0]               first,
  output logic [N_REQ_IDX_BITS-1:0]            first_src,
  output logic                                 notEmpty,
  input  logic                                 deq_en
);

  localparam int N_OUT_BITS = N_DATA_BITS + N_REQ_IDX_BITS;
  localparam int N_SUM_BITS = N_REQ_IDX_BITS + 1;

  // Input buffers: head slot feeds the arbiter, enq slot is the skid entry.
  logic [N_REQ-1:0]       r_in_head_v;
  logic [N_REQ-1:0]       r_in_enq_v;
  logic [N_DATA_BITS-1:0] r_in_head_d [N_REQ];
  logic [N_DATA_BITS-1:0] r_in_enq_d  [N_REQ];
  logic [N_REQ-1:0]       w_in_enq;
  logic [N_REQ-1:0]       w_in_pop;

  // Output buffer carries {source index, payload}.
  logic                   r_out_head_v;
  logic                   r_out_enq_v;
  logic [N_OUT_BITS-1:0]  r_out_head_d;
  logic [N_OUT_BITS-1:0]  r_out_enq_d;
  logic                   w_out_push;
  logic                   w_out_deq;
  logic [N_OUT_BITS-1:0]  w_out_push_d;

  logic [N_REQ_IDX_BITS-1:0] r_ptr;
  logic [N_REQ_IDX_BITS-1:0] w_winner;
  logic [N_REQ_IDX_BITS-1:0] w_ptr_next;
  logic                      w_fire;

  // Enqueues are only honoured into a free enq slot so an illegal strobe cannot
  // corrupt a buffered entry; the protocol check below reports it.
  assign w_in_enq = enq_en & ~r_in_enq_v;

  // Fire whenever the output skid slot is free and any input head is valid.
  assign w_fire     = ~r_out_enq_v & (|r_in_head_v);
  assign w_in_pop   = w_fire ? (N_REQ'(1) << w_winner) : '0;
  assign w_out_push = w_fire;
  assign w_out_deq  = deq_en & r_out_head_v;
  assign w_out_push_d = {w_winner, r_in_head_d[w_winner]};
  assign w_ptr_next = (w_winner == N_REQ_IDX_BITS'(N_REQ - 1)) ?
                      '0 : w_winner + N_REQ_IDX_BITS'(1);

  // Round-robin scan from r_ptr upward, wrapping modulo N_REQ.
  always_comb begin
    logic                      found;
    logic [N_SUM_BITS-1:0]     sum;
    logic [N_REQ_IDX_BITS-1:0] idx;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    w_winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, r_ptr} + N_SUM_BITS'(k);
      if (sum >= N_SUM_BITS'(N_REQ)) begin
        sum = sum - N_SUM_BITS'(N_REQ);
      end
      idx = sum[N_REQ_IDX_BITS-1:0];
      if (!found && r_in_head_v[idx]) begin
        found    = 1'b1;
        w_winner = idx;
      end
    end
  end

  // Round-robin pointer advances past each winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_fire) begin
      r_ptr <= w_ptr_next;
    end
  end

  // Input buffer valid bits; a pop and an enqueue may coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_head_v <= '0;
      r_in_enq_v  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_in_pop[i]) begin
          r_in_head_v[i] <= r_in_enq_v[i] | w_in_enq[i];
          r_in_enq_v[i]  <= 1'b0;
        end else if (w_in_enq[i]) begin
          if (r_in_head_v[i]) begin
            r_in_enq_v[i] <= 1'b1;
          end else begin
            r_in_head_v[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Input buffer payloads; validity alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (w_in_pop[i] && r_in_enq_v[i]) begin
        r_in_head_d[i] <= r_in_enq_d[i];
      end else if (w_in_enq[i] && (w_in_pop[i] || !r_in_head_v[i])) begin
        r_in_head_d[i] <= enq_data[i];
      end
      if (w_in_enq[i] && r_in_head_v[i] && !w_in_pop[i]) begin
        r_in_enq_d[i] <= enq_data[i];
      end
    end
  end

  // Output buffer valid bits; dequeue and arbiter push may coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_head_v <= 1'b0;
      r_out_enq_v  <= 1'b0;
    end else if (w_out_deq) begin
      r_out_head_v <= r_out_enq_v | w_out_push;
      r_out_enq_v  <= 1'b0;
    end else if (w_out_push) begin
      if (r_out_head_v) begin
        r_out_enq_v <= 1'b1;
      end else begin
        r_out_head_v <= 1'b1;
      end
    end
  end

  // Output buffer payloads.
  always_ff @(posedge clk) begin
    if (w_out_deq && r_out_enq_v) begin
      r_out_head_d <= r_out_enq_d;
    end else if (w_out_push && (w_out_deq || !r_out_head_v)) begin
      r_out_head_d <= w_out_push_d;
    end
    if (w_out_push && r_out_head_v && !w_out_deq) begin
      r_out_enq_d <= w_out_push_d;
    end
  end

  assign notFull   = ~r_in_enq_v;
  assign notEmpty  = r_out_head_v;
  assign first     = r_out_head_d[N_DATA_BITS-1:0];
  assign first_src = r_out_head_d[N_OUT_BITS-1:N_DATA_BITS];

  // Protocol misuse by a producer or the consumer is fatal outside reset.
  assert property (@(posedge clk) disable iff (reset) ((enq_en & ~notFull) == '0))
    else $fatal(1, "ENQ to full FIFO");

  assert property (@(posedge clk) disable iff (reset) !(deq_en && !notEmpty))
    else $fatal(1, "DEQ from empty FIFO");

endmodule

// File: tb/tb_cci_mpf_prim_fifo2_rr_arb.sv
// Directed bench for cci_mpf_prim_fifo2_rr_arb (N_REQ=4, N_DATA_BITS=32).
module tb_cci_mpf_prim_fifo2_rr_arb;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0][31:0]  enq_data;
  logic [3:0]        enq_en;
  logic [3:0]        notFull;
  logic [31:0]       first;
  logic [1:0]        first_src;
  logic              notEmpty;
  logic              deq_en;

  int n_asserts = 0;
  int n_fail    = 0;

  cci_mpf_prim_fifo2_rr_arb #(.N_DATA_BITS(32), .N_REQ(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_data  (enq_data),
    .enq_en    (enq_en),
    .notFull   (notFull),
    .first     (first),
    .first_src (first_src),
    .notEmpty  (notEmpty),
    .deq_en    (deq_en)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] src, input logic [31:0] data);
    check({tag, "_notEmpty"}, 32'(notEmpty), 32'd1);
    check({tag, "_src"}, 32'(first_src), src);
    check({tag, "_data"}, first, data);
  endtask

  task automatic pulse_reset();
    reset  = 1'b1;
    enq_en = '0;
    deq_en = 1'b0;
    cyc();
    reset  = 1'b0;
  endtask

  initial begin
    int sent [4];
    int got  [4];
    int n_out;
    int exp_src;
    int k;
    bit started;

    reset    = 1'b0;
    enq_en   = '0;
    deq_en   = 1'b0;
    enq_data = '0;

    // Reset state, visible before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_notFull", 32'(notFull), 32'hF);
    check("rst_notEmpty", 32'(notEmpty), 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    check("rst_rel_notFull", 32'(notFull), 32'hF);

    // Single enqueue on requester 2: head appears two cycles later.
    enq_en      = 4'b0100;
    enq_data[2] = 32'hA5;
    cyc();
    enq_en = '0;
    check("single_c2_notEmpty", 32'(notEmpty), 32'd0);
    check("single_c2_notFull", 32'(notFull), 32'hF);
    cyc();
    check_head("single_c3", 32'd2, 32'hA5);
    deq_en = 1'b1;
    cyc();
    deq_en = 1'b0;
    check("single_c4_notEmpty", 32'(notEmpty), 32'd0);

    // Full contention with the consumer always draining.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0;
      got[i]  = 0;
    end
    n_out   = 0;
    exp_src = 0;
    started = 1'b0;
    for (int c = 0; c < 40 && n_out < 16; c++) begin
      if (notEmpty) begin
        check("cont_src", 32'(first_src), 32'(exp_src));
        check("cont_data", first, {8'(exp_src), 24'(got[exp_src])});
        got[exp_src]++;
        exp_src = (exp_src + 1) % 4;
        n_out++;
        started = 1'b1;
      end else if (started) begin
        check("cont_gap", 32'(notEmpty), 32'd1);
      end
      deq_en = notEmpty;
      for (int i = 0; i < 4; i++) begin
        enq_en[i]   = notFull[i];
        enq_data[i] = {8'(i), 24'(sent[i])};
        if (notFull[i]) sent[i]++;
      end
      cyc();
    end
    check("cont_count", 32'(n_out), 32'd16);

    // Backpressure: consumer stalled while every requester pushes.
    pulse_reset();
    for (int i = 0; i < 4; i++) sent[i] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) begin
        enq_en[i]   = notFull[i];
        enq_data[i] = {8'(i), 24'(sent[i])};
        if (notFull[i]) sent[i]++;
      end
      cyc();
    end
    enq_en = '0;
    check("bp_notFull", 32'(notFull), 32'h0);
    check("bp_total", 32'(sent[0] + sent[1] + sent[2] + sent[3]), 32'd10);
    check_head("bp_head", 32'd0, 32'h0000_0000);
    k = 0;
    for (int c = 0; c < 30 && k < 10; c++) begin
      if (notEmpty) begin
        check("bp_drain_src", 32'(first_src), 32'(k % 4));
        check("bp_drain_data", first, {8'(k % 4), 24'(k / 4)});
        k++;
      end
      deq_en = notEmpty;
      cyc();
    end
    deq_en = 1'b0;
    check("bp_drain_count", 32'(k), 32'd10);
    check("bp_empty", 32'(notEmpty), 32'd0);
    check("bp_notFull_after", 32'(notFull), 32'hF);

    // Sparse requests: grant 3, wrap to 1, then the pointer sits at 2.
    pulse_reset();
    enq_en      = 4'b1000;
    enq_data[3] = 32'h30;
    cyc();
    enq_en      = 4'b1010;
    enq_data[3] = 32'h31;
    enq_data[1] = 32'h10;
    cyc();
    enq_en      = 4'b0101;
    enq_data[0] = 32'h05;
    enq_data[2] = 32'h20;
    check_head("sparse_g3", 32'd3, 32'h30);
    deq_en = 1'b1;
    cyc();
    enq_en = '0;
    check_head("sparse_g1", 32'd1, 32'h10);
    cyc();
    check_head("sparse_g2", 32'd2, 32'h20);
    cyc();
    check_head("sparse_g3b", 32'd3, 32'h31);
    cyc();
    check_head("sparse_g0", 32'd0, 32'h05);
    cyc();
    deq_en = 1'b0;
    check("sparse_empty", 32'(notEmpty), 32'd0);

    // Asynchronous reset in the middle of a stalled stream.
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        enq_en[i]   = notFull[i];
        enq_data[i] = {16'hDEAD, 16'(i)};
      end
      cyc();
    end
    check("ar_pre_notEmpty", 32'(notEmpty), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_async_notEmpty", 32'(notEmpty), 32'd0);
    check("ar_async_notFull", 32'(notFull), 32'hF);
    enq_en = 4'hF;
    deq_en = 1'b1;
    cyc();
    cyc();
    check("ar_held_notEmpty", 32'(notEmpty), 32'd0);
    check("ar_held_notFull", 32'(notFull), 32'hF);
    reset  = 1'b0;
    enq_en = '0;
    deq_en = 1'b0;
    cyc();
    check("ar_rel1_notEmpty", 32'(notEmpty), 32'd0);
    cyc();
    check("ar_rel2_notEmpty", 32'(notEmpty), 32'd0);
    check("ar_rel2_notFull", 32'(notFull), 32'hF);
    enq_en      = 4'b1001;
    enq_data[0] = 32'hBEEF;
    enq_data[3] = 32'h3333;
    cyc();
    enq_en = '0;
    cyc();
    check_head("ar_first0", 32'd0, 32'hBEEF);
    deq_en = 1'b1;
    cyc();
    check_head("ar_then3", 32'd3, 32'h3333);
    cyc();
    deq_en = 1'b0;
    check("ar_final_empty", 32'(notEmpty), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
